// File: rtl/uart_serdes_cfg.sv
// Full-duplex UART with configurable data bits, parity and stop bits, and
// first-word fall-through TX/RX FIFOs. RX entries carry per-byte frame/parity flags.
module uart_serdes_cfg #(
   parameter int unsigned CLK_FREQ  = 33333333,
   parameter int unsigned BAUD      = 9600,
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1,
   parameter int unsigned FIFO_AW   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tx_fifo_wr_en_in,
   input  logic [DATA_BITS-1:0] tx_fifo_data_in,
   output logic                 tx_fifo_full_out,
   output logic                 tx_busy_out,
   input  logic                 rx_fifo_rd_en_in,
   output logic                 rx_fifo_empty_out,
   output logic [DATA_BITS-1:0] rx_fifo_dout_out,
   output logic                 rx_frame_err_out,
   output logic                 rx_parity_err_out,
   output logic                 rx_overrun_out,
   input  logic                 rx_err_clr_in,
   input  logic                 rx,
   output logic                 tx
);
   localparam int unsigned DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
   localparam int unsigned CW    = $clog2(DIV + 1);
   localparam int unsigned BW    = $clog2(DATA_BITS + 1);
   localparam int unsigned DEPTH = 2 ** FIFO_AW;
   localparam int unsigned RXW   = DATA_BITS + 2;
   localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
   localparam logic ODD = (PARITY == 1);

   // TX FIFO
   logic [DATA_BITS-1:0] tx_mem [DEPTH];
   logic [FIFO_AW-1:0]   tx_wptr_q, tx_rptr_q;
   logic [FIFO_AW:0]     tx_cnt_q, tx_cnt_d;
   logic                 tx_full_q, tx_empty_q, tx_wr_ok, tx_pop;
   logic [DATA_BITS-1:0] tx_head;

   assign tx_wr_ok = tx_fifo_wr_en_in && (!tx_full_q || tx_pop);
   assign tx_head  = tx_mem[tx_rptr_q];

   always_comb begin
      tx_cnt_d = tx_cnt_q;
      if (tx_wr_ok && !tx_pop)      tx_cnt_d = tx_cnt_q + 1'b1;
      else if (!tx_wr_ok && tx_pop) tx_cnt_d = tx_cnt_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_wptr_q  <= '0;
         tx_rptr_q  <= '0;
         tx_cnt_q   <= '0;
         tx_full_q  <= 1'b0;
         tx_empty_q <= 1'b1;
      end else begin
         if (tx_wr_ok) tx_wptr_q <= tx_wptr_q + 1'b1;
         if (tx_pop)   tx_rptr_q <= tx_rptr_q + 1'b1;
         tx_cnt_q   <= tx_cnt_d;
         tx_full_q  <= (tx_cnt_d == FULL_CNT);
         tx_empty_q <= (tx_cnt_d == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (tx_wr_ok) tx_mem[tx_wptr_q] <= tx_fifo_data_in;
   end

   // TX FSM
   typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
   tx_state_e            tx_state_q, tx_state_d;
   logic [CW-1:0]        tx_div_q, tx_div_d;
   logic [BW-1:0]        tx_bit_q, tx_bit_d;
   logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
   logic                 tx_par_q, tx_par_d, tx_line, tx_q, tx_busy_q, tx_end;

   assign tx_end = (tx_div_q == '0);

   always_comb begin
      tx_state_d = tx_state_q;
      tx_div_d   = tx_div_q;
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      tx_par_d   = tx_par_q;
      tx_pop     = 1'b0;
      tx_line    = 1'b1;
      if (tx_state_q != TxIdle && !tx_end) tx_div_d = tx_div_q - 1'b1;
      unique case (tx_state_q)
         TxIdle:  tx_pop = !tx_empty_q;
         TxStart: begin
            tx_line = 1'b0;
            if (tx_end) begin
               tx_state_d = TxData;
               tx_div_d   = CW'(DIV - 1);
               tx_bit_d   = '0;
            end
         end
         TxData: begin
            tx_line = tx_sh_q[0];
            if (tx_end) begin
               tx_div_d = CW'(DIV - 1);
               tx_sh_d  = tx_sh_q >> 1;
               tx_bit_d = tx_bit_q + 1'b1;
               if (tx_bit_q == BW'(DATA_BITS - 1)) begin
                  tx_state_d = (PARITY != 0) ? TxParity : TxStop;
                  tx_bit_d   = '0;
               end
            end
         end
         TxParity: begin
            tx_line = tx_par_q;
            if (tx_end) begin
               tx_state_d = TxStop;
               tx_div_d   = CW'(DIV - 1);
            end
         end
         TxStop: begin
            if (tx_end) begin
               if (STOP_BITS == 2 && tx_bit_q == '0) begin
                  tx_bit_d = 1'b1;
                  tx_div_d = CW'(DIV - 1);
               end else begin
                  tx_state_d = TxIdle;
                  tx_pop     = !tx_empty_q;
               end
            end
         end
         default: tx_state_d = TxIdle;
      endcase
      // A pop always starts a new frame, from idle or straight out of the last stop bit.
      if (tx_pop) begin
         tx_state_d = TxStart;
         tx_div_d   = CW'(DIV - 1);
         tx_sh_d    = tx_head;
         tx_par_d   = (^tx_head) ^ ODD;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state_q <= TxIdle;
         tx_div_q   <= '0;
         tx_bit_q   <= '0;
         tx_sh_q    <= '0;
         tx_par_q   <= 1'b0;
         tx_q       <= 1'b1;
         tx_busy_q  <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_div_q   <= tx_div_d;
         tx_bit_q   <= tx_bit_d;
         tx_sh_q    <= tx_sh_d;
         tx_par_q   <= tx_par_d;
         tx_q       <= tx_line;
         tx_busy_q  <= (tx_state_q != TxIdle) || !tx_empty_q;
      end
   end

   assign tx               = tx_q;
   assign tx_busy_out      = tx_busy_q;
   assign tx_fifo_full_out = tx_full_q;

   // RX synchroniser and FSM
   typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;
   rx_state_e            rx_state_q, rx_state_d;
   logic                 rx_meta_q, rx_sync_q, rx_prev_q;
   logic [CW-1:0]        rx_div_q, rx_div_d;
   logic [BW-1:0]        rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
   logic                 rx_perr_q, rx_perr_d, rx_push, rx_end;

   assign rx_end = (rx_div_q == '0);

   always_comb begin
      rx_state_d = rx_state_q;
      rx_div_d   = rx_div_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_perr_d  = rx_perr_q;
      rx_push    = 1'b0;
      if (rx_state_q != RxIdle && !rx_end) rx_div_d = rx_div_q - 1'b1;
      unique case (rx_state_q)
         RxIdle: begin
            if (rx_prev_q && !rx_sync_q) begin
               rx_state_d = RxStart;
               rx_div_d   = CW'(DIV / 2 - 1);
            end
         end
         RxStart: begin
            if (rx_end) begin
               rx_state_d = rx_sync_q ? RxIdle : RxData;
               rx_div_d   = CW'(DIV - 1);
               rx_bit_d   = '0;
               rx_perr_d  = 1'b0;
            end
         end
         RxData: begin
            if (rx_end) begin
               rx_div_d = CW'(DIV - 1);
               rx_sh_d  = {rx_sync_q, rx_sh_q[DATA_BITS-1:1]};
               rx_bit_d = rx_bit_q + 1'b1;
               if (rx_bit_q == BW'(DATA_BITS - 1)) rx_state_d = (PARITY != 0) ? RxParity : RxStop;
            end
         end
         RxParity: begin
            if (rx_end) begin
               rx_state_d = RxStop;
               rx_div_d   = CW'(DIV - 1);
               rx_perr_d  = rx_sync_q ^ (^rx_sh_q) ^ ODD;
            end
         end
         RxStop: begin
            if (rx_end) begin
               rx_state_d = RxIdle;
               rx_push    = 1'b1;
            end
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RxIdle;
         rx_div_q   <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         rx_perr_q  <= 1'b0;
      end else begin
         rx_meta_q  <= rx;
         rx_sync_q  <= rx_meta_q;
         rx_prev_q  <= rx_sync_q;
         rx_state_q <= rx_state_d;
         rx_div_q   <= rx_div_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
         rx_perr_q  <= rx_perr_d;
      end
   end

   // RX FIFO: entry = {frame_err, parity_err, data}
   logic [RXW-1:0]     rx_mem [DEPTH];
   logic [RXW-1:0]     rx_head;
   logic [FIFO_AW-1:0] rx_wptr_q, rx_rptr_q;
   logic [FIFO_AW:0]   rx_cnt_q, rx_cnt_d;
   logic               rx_full_q, rx_empty_q, rx_wr_ok, rx_rd_ok, rx_ovr_q;

   assign rx_wr_ok = rx_push && (!rx_full_q || rx_fifo_rd_en_in);
   assign rx_rd_ok = rx_fifo_rd_en_in && (!rx_empty_q || rx_push);
   assign rx_head  = rx_mem[rx_rptr_q];

   always_comb begin
      rx_cnt_d = rx_cnt_q;
      if (rx_wr_ok && !rx_rd_ok)      rx_cnt_d = rx_cnt_q + 1'b1;
      else if (!rx_wr_ok && rx_rd_ok) rx_cnt_d = rx_cnt_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_wptr_q  <= '0;
         rx_rptr_q  <= '0;
         rx_cnt_q   <= '0;
         rx_full_q  <= 1'b0;
         rx_empty_q <= 1'b1;
         rx_ovr_q   <= 1'b0;
      end else begin
         if (rx_wr_ok) rx_wptr_q <= rx_wptr_q + 1'b1;
         if (rx_rd_ok) rx_rptr_q <= rx_rptr_q + 1'b1;
         rx_cnt_q   <= rx_cnt_d;
         rx_full_q  <= (rx_cnt_d == FULL_CNT);
         rx_empty_q <= (rx_cnt_d == '0);
         // A dropped frame wins over a clear in the same cycle.
         if (rx_push && !rx_wr_ok) rx_ovr_q <= 1'b1;
         else if (rx_err_clr_in)   rx_ovr_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rx_wr_ok) rx_mem[rx_wptr_q] <= {!rx_sync_q, rx_perr_q, rx_sh_q};
   end

   assign rx_fifo_empty_out = rx_empty_q;
   assign rx_fifo_dout_out  = rx_empty_q ? '0 : rx_head[DATA_BITS-1:0];
   assign rx_parity_err_out = !rx_empty_q && rx_head[DATA_BITS];
   assign rx_frame_err_out  = !rx_empty_q && rx_head[DATA_BITS+1];
   assign rx_overrun_out    = rx_ovr_q;
endmodule
